// File: rtl/divider_pkg.sv
// ============================================================================
// Module   : divider_pkg
// Purpose  : Shared FSM encodings and conditional-negate helper for seq_divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package divider_pkg;

   localparam int c_MAX_WIDTH = 64;

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_CALC    = 3'd1;
   localparam logic [2:0] c_ST_CORRECT = 3'd2;
   localparam logic [2:0] c_ST_FIXSIGN = 3'd3;
   localparam logic [2:0] c_ST_DONE    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = c_ST_IDLE,
      CALC    = c_ST_CALC,
      CORRECT = c_ST_CORRECT,
      FIXSIGN = c_ST_FIXSIGN,
      DONE    = c_ST_DONE
   } state_t;

   // Callers truncate the result back to their own width; the low bits of a
   // wide two's-complement negate equal the narrow negate.
   function automatic logic [c_MAX_WIDTH-1:0] cond_negate(
      input logic [c_MAX_WIDTH-1:0] value,
      input logic                   negate
   );
      return negate ? (~value + 1'b1) : value;
   endfunction

endpackage

`default_nettype wire

// File: rtl/add_sub.sv
// ============================================================================
// Module   : add_sub
// Purpose  : Combinational adder/subtractor, y = sub ? a - b : a + b.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module add_sub #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic [WIDTH-1:0] o_result
);

   assign o_result = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Purpose  : Self-sequencing non-restoring integer divider, signed/unsigned.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider
   import divider_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SIGNED_EN = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       signed_mode,
   input  logic [WIDTH-1:0]           dividend,
   input  logic [WIDTH-1:0]           divisor,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           quotient,
   output logic [WIDTH-1:0]           remainder,
   output logic                       div_by_zero,
   output logic                       overflow,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int               c_CNT_W = $clog2(WIDTH+1);
   localparam logic [WIDTH-1:0] c_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             r_state;
   state_t             w_next;
   logic [c_CNT_W-1:0] r_count;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dvsr_mag;
   logic [WIDTH-1:0]   r_dividend;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_signed;
   logic               r_sign_q;
   logic               r_sign_r;

   logic               w_signed;
   logic               w_neg_dvnd;
   logic               w_neg_dvsr;
   logic [WIDTH-1:0]   w_dvnd_mag;
   logic [WIDTH-1:0]   w_dvsr_mag;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_alu_a;
   logic [WIDTH:0]     w_alu_b;
   logic [WIDTH:0]     w_alu_y;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic               w_ovf;

   assign w_signed   = (SIGNED_EN != 0) && signed_mode;
   assign w_neg_dvnd = w_signed && dividend[WIDTH-1];
   assign w_neg_dvsr = w_signed && divisor[WIDTH-1];
   assign w_dvnd_mag = WIDTH'(cond_negate(64'(dividend), w_neg_dvnd));
   assign w_dvsr_mag = WIDTH'(cond_negate(64'(divisor), w_neg_dvsr));

   // CALC feeds the shifted remainder; CORRECT feeds R itself (add when R < 0).
   assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
   assign w_alu_a  = (r_state == CALC) ? w_rem_sh : r_rem;
   assign w_alu_b  = {1'b0, r_dvsr_mag};

   add_sub #(
      .WIDTH (WIDTH+1)
   ) u_add_sub (
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .i_sub    (~r_rem[WIDTH]),
      .o_result (w_alu_y)
   );

   assign w_quo_fix = WIDTH'(cond_negate(64'(r_quo), r_sign_q));
   assign w_rem_fix = WIDTH'(cond_negate(64'(r_rem[WIDTH-1:0]), r_sign_r));
   assign w_ovf     = r_signed && (r_dividend == c_MIN) && (r_divisor == '1);

   assign count = r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = (divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (r_count == c_CNT_W'(1)) begin
               w_next = CORRECT;
            end
         end
         CORRECT: begin
            busy   = 1'b1;
            w_next = FIXSIGN;
         end
         FIXSIGN: begin
            busy   = 1'b1;
            w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvsr_mag  <= '0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_signed    <= 1'b0;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dividend  <= dividend;
                  r_divisor   <= divisor;
                  r_signed    <= w_signed;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     r_sign_q   <= w_neg_dvnd ^ w_neg_dvsr;
                     r_sign_r   <= w_neg_dvnd;
                     r_rem      <= '0;
                     r_quo      <= w_dvnd_mag;
                     r_dvsr_mag <= w_dvsr_mag;
                     r_count    <= c_CNT_W'(WIDTH);
                  end
               end
            end
            CALC: begin
               r_rem   <= w_alu_y;
               r_quo   <= {r_quo[WIDTH-2:0], ~w_alu_y[WIDTH]};
               r_count <= r_count - 1'b1;
            end
            CORRECT: begin
               if (r_rem[WIDTH]) begin
                  r_rem <= w_alu_y;
               end
            end
            FIXSIGN: begin
               quotient  <= w_quo_fix;
               remainder <= w_rem_fix;
               overflow  <= w_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider at WIDTH=8 and WIDTH=16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        signed_mode = 1'b0;
   logic        start8 = 1'b0;
   logic        start16 = 1'b0;
   logic [7:0]  dvd8 = '0, dvs8 = '0;
   logic [15:0] dvd16 = '0, dvs16 = '0;

   logic        busy8, done8, dz8, ov8;
   logic [7:0]  q8, r8;
   logic [3:0]  cnt8;
   logic        busy16, done16, dz16, ov16;
   logic [15:0] q16, r16;
   logic [4:0]  cnt16;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(signed_mode),
      .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8),
      .count(cnt8)
   );

   seq_divider #(.WIDTH(16), .SIGNED_EN(1)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(signed_mode),
      .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
      .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16),
      .count(cnt16)
   );

   typedef struct {
      int          w;
      bit          sm;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      bit          dz;
      bit          ov;
   } vec_t;

   function automatic logic        get_busy(input int w); return (w == 8) ? busy8 : busy16; endfunction
   function automatic logic        get_done(input int w); return (w == 8) ? done8 : done16; endfunction
   function automatic logic        get_dz(input int w);   return (w == 8) ? dz8 : dz16;     endfunction
   function automatic logic        get_ov(input int w);   return (w == 8) ? ov8 : ov16;     endfunction
   function automatic logic [15:0] get_q(input int w);    return (w == 8) ? {8'h00, q8} : q16; endfunction
   function automatic logic [15:0] get_r(input int w);    return (w == 8) ? {8'h00, r8} : r16; endfunction
   function automatic int          get_cnt(input int w);  return (w == 8) ? int'(cnt8) : int'(cnt16); endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input int w, input bit sm, input logic [15:0] a,
                        input logic [15:0] b, input logic st);
      signed_mode = sm;
      if (w == 8) begin
         dvd8 = a[7:0]; dvs8 = b[7:0]; start8 = st;
      end else begin
         dvd16 = a; dvs16 = b; start16 = st;
      end
   endtask

   task automatic set_start(input int w, input logic st);
      if (w == 8) start8 = st;
      else        start16 = st;
   endtask

   // Reference: plain integer division, truncating toward zero.
   task automatic model(input int w, input bit sm, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] q,
                        output logic [15:0] r, output bit dz, output bit ov);
      logic [15:0] mask;
      longint      sa, sb, half;
      mask = (w == 8) ? 16'h00FF : 16'hFFFF;
      half = (w == 8) ? 128 : 32768;
      dz = 1'b0; ov = 1'b0;
      if (b == 16'd0) begin
         q = mask; r = a; dz = 1'b1;
      end else if (!sm) begin
         q = a / b; r = a % b;
      end else begin
         sa = (w == 8) ? longint'($signed(a[7:0])) : longint'($signed(a));
         sb = (w == 8) ? longint'($signed(b[7:0])) : longint'($signed(b));
         if (sa == -half && sb == -1) begin
            q = 16'(half); r = 16'd0; ov = 1'b1;
         end else begin
            q = 16'(sa / sb) & mask;
            r = 16'(sa % sb) & mask;
         end
      end
   endtask

   // Issues one operation and checks results and timing. With after_done the
   // call is made in the DONE cycle of the previous op: start is held through
   // the (ignored) DONE edge and taken on the following IDLE edge.
   task automatic do_op(input string tag, input int w, input bit sm,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input bit edz, input bit eov, input bit after_done,
                        input int pulse_at);
      int lat, bc;
      drive(w, sm, a, b, 1'b1);
      if (after_done) begin
         @(posedge clk); #1;
         check({tag, "_done_pulse_end"}, {get_busy(w), get_done(w)}, 0);
      end
      lat = 0; bc = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            drive(w, ~sm, 16'($urandom), 16'($urandom), 1'b0);
            if (!edz) check({tag, "_count_load"}, get_cnt(w), w);
         end
         if (pulse_at != 0 && lat == pulse_at) drive(w, 1'b0, 16'd100, 16'd7, 1'b1);
         if (pulse_at != 0 && lat == pulse_at + 1) set_start(w, 1'b0);
         if (get_busy(w)) bc++;
      end while (!get_done(w) && lat < 64);
      check({tag, "_done_seen"}, get_done(w), 1);
      check({tag, "_quotient"}, get_q(w), eq);
      check({tag, "_remainder"}, get_r(w), er);
      check({tag, "_div_by_zero"}, get_dz(w), edz);
      check({tag, "_overflow"}, get_ov(w), eov);
      check({tag, "_latency"}, lat, edz ? 1 : w + 3);
      check({tag, "_busy_cycles"}, bc, edz ? 0 : w + 2);
   endtask

   task automatic idle_edge(input int w, input string tag);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, get_done(w), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[11];
      logic [15:0] a, b, eq, er, mask;
      bit          edz, eov, sm, b2b;
      int          ones, sel;

      tbl[0]  = '{w: 8,  sm: 1'b0, a: 16'd201,   b: 16'd5,    q: 16'd40,    r: 16'd1,    dz: 1'b0, ov: 1'b0};
      tbl[1]  = '{w: 8,  sm: 1'b1, a: 16'h00F9,  b: 16'h0002, q: 16'h00FD,  r: 16'h00FF, dz: 1'b0, ov: 1'b0};
      tbl[2]  = '{w: 8,  sm: 1'b1, a: 16'h0007,  b: 16'h00FE, q: 16'h00FD,  r: 16'h0001, dz: 1'b0, ov: 1'b0};
      tbl[3]  = '{w: 8,  sm: 1'b0, a: 16'd37,    b: 16'd0,    q: 16'h00FF,  r: 16'd37,   dz: 1'b1, ov: 1'b0};
      tbl[4]  = '{w: 8,  sm: 1'b0, a: 16'd100,   b: 16'd7,    q: 16'd14,    r: 16'd2,    dz: 1'b0, ov: 1'b0};
      tbl[5]  = '{w: 8,  sm: 1'b1, a: 16'h0080,  b: 16'h00FF, q: 16'h0080,  r: 16'h0000, dz: 1'b0, ov: 1'b1};
      tbl[6]  = '{w: 8,  sm: 1'b0, a: 16'h0080,  b: 16'h00FF, q: 16'h0000,  r: 16'h0080, dz: 1'b0, ov: 1'b0};
      tbl[7]  = '{w: 16, sm: 1'b0, a: 16'd1000,  b: 16'd0,    q: 16'hFFFF,  r: 16'd1000, dz: 1'b1, ov: 1'b0};
      tbl[8]  = '{w: 16, sm: 1'b1, a: 16'h8000,  b: 16'hFFFF, q: 16'h8000,  r: 16'h0000, dz: 1'b0, ov: 1'b1};
      tbl[9]  = '{w: 16, sm: 1'b1, a: 16'hFFF9,  b: 16'h0002, q: 16'hFFFD,  r: 16'hFFFF, dz: 1'b0, ov: 1'b0};
      tbl[10] = '{w: 16, sm: 1'b0, a: 16'd65535, b: 16'd255,  q: 16'h0101,  r: 16'h0000, dz: 1'b0, ov: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check("reset_dut8", {busy8, done8, dz8, ov8, q8, r8, cnt8}, 0);
      check("reset_dut16", {busy16, done16, dz16, ov16, q16, r16, cnt16}, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         do_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].sm, tbl[i].a, tbl[i].b,
               tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, 1'b0, 0);
         idle_edge(tbl[i].w, $sformatf("vec%0d", i));
      end

      // start pulsed mid-CALC with other operands must be ignored
      do_op("start_in_calc", 8, 1'b0, 16'd201, 16'd5, 16'd40, 16'd1, 1'b0, 1'b0, 1'b0, 4);
      idle_edge(8, "start_in_calc");

      // reset asserted mid-CALC aborts with no done pulse
      drive(8, 1'b0, 16'd201, 16'd5, 1'b1);
      @(posedge clk); #1;
      set_start(8, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("reset_abort", {busy8, done8, dz8, ov8, q8, r8, cnt8}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      ones = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done8 || busy8) ones++;
      end
      check("reset_abort_no_done", ones, 0);

      for (int wi = 0; wi < 2; wi++) begin
         int w;
         w = (wi == 0) ? 8 : 16;
         mask = (w == 8) ? 16'h00FF : 16'hFFFF;
         for (int k = 0; k < 150; k++) begin
            sm = 1'($urandom_range(0, 1));
            a = 16'($urandom) & mask;
            b = 16'($urandom) & mask;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = 16'd0;
            else if (sel == 1) begin a = (mask >> 1) + 16'd1; b = mask; end
            else if (sel == 2) b = 16'($urandom_range(1, 3));
            else if (sel == 3) a = 16'($urandom_range(0, 3));
            model(w, sm, a, b, eq, er, edz, eov);
            b2b = (k > 0) && ($urandom_range(0, 1) == 1);
            if (k > 0 && !b2b) begin
               idle_edge(w, $sformatf("rnd%0d_%0d", w, k));
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
            do_op($sformatf("rnd%0d_%0d", w, k), w, sm, a, b, eq, er, edz, eov, b2b, 0);
         end
         idle_edge(w, $sformatf("rnd%0d_end", w));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
